// File: rtl/bp_pkg.sv
// Shared BTB entry type, branch-type codes and counter helpers for the tournament predictor.
package bp_pkg;

   // Entry fields are sized for the widest supported address; unused upper bits stay zero.
   localparam int ADDR_MAX = 64;

   localparam logic [1:0] BT_COND = 2'b00;
   localparam logic [1:0] BT_CALL = 2'b01;
   localparam logic [1:0] BT_RET  = 2'b10;
   localparam logic [1:0] BT_JUMP = 2'b11;

   typedef struct packed {
      logic                valid;
      logic [ADDR_MAX-1:0] tag;
      logic [ADDR_MAX-1:0] target;
      logic [1:0]          btype;
   } btb_entry_t;

   function automatic logic [1:0] sat_inc(input logic [1:0] c);
      return (c == 2'b11) ? c : c + 2'b01;
   endfunction

   function automatic logic [1:0] sat_dec(input logic [1:0] c);
      return (c == 2'b00) ? c : c - 2'b01;
   endfunction

   function automatic logic [ADDR_MAX-1:0] make_gshare_idx(input logic [ADDR_MAX-1:0] ghr,
                                                           input logic [ADDR_MAX-1:0] pc,
                                                           input int idx_bits);
      logic [ADDR_MAX-1:0] mask;
      mask = (ADDR_MAX'(1) << idx_bits) - ADDR_MAX'(1);
      return (ghr ^ (pc >> 2)) & mask;
   endfunction

endpackage

// File: rtl/bp_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
// Requests are applied in port order within one cycle; flush empties the stack.
module bp_ras #(
   parameter int ADDR_W  = 32,
   parameter int DEPTH   = 8,
   parameter int NUM_UPD = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic [NUM_UPD-1:0]        push,
   input  logic [NUM_UPD-1:0]        pop,
   input  logic [NUM_UPD*ADDR_W-1:0] push_addr,
   output logic [$clog2(DEPTH):0]    count,
   output logic [ADDR_W-1:0]         top
);
   localparam int PW = $clog2(DEPTH);

   logic [ADDR_W-1:0] mem_q [DEPTH];
   logic [ADDR_W-1:0] mem_d [DEPTH];
   logic [PW-1:0]     ptr_q, ptr_d;
   logic [PW:0]       cnt_q, cnt_d;

   always_comb begin
      mem_d = mem_q;
      ptr_d = ptr_q;
      cnt_d = cnt_q;
      for (int p = 0; p < NUM_UPD; p++) begin
         if (push[p]) begin
            mem_d[ptr_d] = push_addr[p*ADDR_W +: ADDR_W];
            ptr_d        = ptr_d + PW'(1);
            if (cnt_d != (PW+1)'(DEPTH))
               cnt_d = cnt_d + (PW+1)'(1);
         end else if (pop[p] && (cnt_d != '0)) begin
            ptr_d = ptr_d - PW'(1);
            cnt_d = cnt_d - (PW+1)'(1);
         end
      end
      if (flush) begin
         ptr_d = '0;
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
         cnt_q <= '0;
      end else begin
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign top   = mem_q[ptr_q - PW'(1)];
   assign count = cnt_q;

endmodule

// File: rtl/bp_tournament.sv
// Tournament (gshare/bimodal/chooser) direction predictor with 2-way typed BTB, speculative GHR and RAS.
// Prediction is combinational from fetch_pc; resolution ports update state in port order each cycle.
module bp_tournament
   import bp_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int GHR_BITS     = 8,
   parameter int IDX_BITS     = 8,
   parameter int BTB_IDX_BITS = 6,
   parameter int RAS_DEPTH    = 8,
   parameter int NUM_UPD      = 2,
   parameter int FETCH_STRIDE = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        flush,
   input  logic                        fetch_valid,
   input  logic [ADDR_W-1:0]           fetch_pc,
   output logic                        pred_taken,
   output logic [ADDR_W-1:0]           pred_target,
   output logic [GHR_BITS-1:0]         pred_hist,
   output logic                        pred_btb_hit,
   input  logic [NUM_UPD-1:0]          upd_valid,
   input  logic [NUM_UPD*ADDR_W-1:0]   upd_pc,
   input  logic [NUM_UPD-1:0]          upd_taken,
   input  logic [NUM_UPD*ADDR_W-1:0]   upd_target,
   input  logic [NUM_UPD*GHR_BITS-1:0] upd_hist,
   input  logic [NUM_UPD-1:0]          upd_is_call,
   input  logic [NUM_UPD-1:0]          upd_is_return,
   input  logic [NUM_UPD-1:0]          upd_is_jump,
   input  logic [NUM_UPD-1:0]          upd_mispredict
);
   localparam int TBL  = 1 << IDX_BITS;
   localparam int SETS = 1 << BTB_IDX_BITS;

   logic [1:0]          gsh_q [TBL];
   logic [1:0]          gsh_d [TBL];
   logic [1:0]          bim_q [TBL];
   logic [1:0]          bim_d [TBL];
   logic [1:0]          cho_q [TBL];
   logic [1:0]          cho_d [TBL];
   btb_entry_t          btb_q [SETS][2];
   btb_entry_t          btb_d [SETS][2];
   logic [SETS-1:0]     lru_q, lru_d;
   logic [GHR_BITS-1:0] ghr_q, ghr_d;

   logic [$clog2(RAS_DEPTH):0] ras_cnt;
   logic [ADDR_W-1:0]          ras_top;
   logic [NUM_UPD-1:0]         ras_push, ras_pop;
   logic [NUM_UPD*ADDR_W-1:0]  ras_addr;

   function automatic logic [IDX_BITS-1:0] pc_idx(input logic [ADDR_W-1:0] pc);
      return pc[IDX_BITS+1:2];
   endfunction

   function automatic logic [IDX_BITS-1:0] gsh_idx(input logic [GHR_BITS-1:0] h,
                                                  input logic [ADDR_W-1:0] pc);
      return IDX_BITS'(make_gshare_idx(ADDR_MAX'(h), ADDR_MAX'(pc), IDX_BITS));
   endfunction

   function automatic logic [BTB_IDX_BITS-1:0] btb_set(input logic [ADDR_W-1:0] pc);
      return pc[BTB_IDX_BITS+1:2];
   endfunction

   function automatic logic [ADDR_MAX-1:0] btb_tag(input logic [ADDR_W-1:0] pc);
      return ADDR_MAX'(pc[ADDR_W-1:BTB_IDX_BITS+2]);
   endfunction

   logic [BTB_IDX_BITS-1:0] f_set;
   logic [ADDR_MAX-1:0]     f_tag;
   logic                    f_hit0, f_hit1, f_hit, f_dir;
   btb_entry_t              f_ent;
   logic [IDX_BITS-1:0]     f_bidx, f_gidx;

   always_comb begin
      f_set  = btb_set(fetch_pc);
      f_tag  = btb_tag(fetch_pc);
      f_hit0 = btb_q[f_set][0].valid && (btb_q[f_set][0].tag == f_tag);
      f_hit1 = btb_q[f_set][1].valid && (btb_q[f_set][1].tag == f_tag);
      f_hit  = f_hit0 | f_hit1;
      f_ent  = f_hit0 ? btb_q[f_set][0] : btb_q[f_set][1];
      f_bidx = pc_idx(fetch_pc);
      f_gidx = gsh_idx(ghr_q, fetch_pc);
      f_dir  = cho_q[f_bidx][1] ? gsh_q[f_gidx][1] : bim_q[f_bidx][1];
      pred_taken = fetch_valid & f_hit & ((f_ent.btype != BT_COND) | f_dir);
      if (f_hit && (f_ent.btype == BT_RET) && (ras_cnt != '0))
         pred_target = ras_top;
      else if (f_hit)
         pred_target = ADDR_W'(f_ent.target);
      else
         pred_target = fetch_pc + ADDR_W'(FETCH_STRIDE);
   end

   assign pred_btb_hit = f_hit;
   assign pred_hist    = ghr_q;

   // Oldest mispredicting port restores history; otherwise fetch shifts in its own prediction.
   always_comb begin
      logic found;
      found = 1'b0;
      ghr_d = ghr_q;
      if (flush) begin
         ghr_d = '0;
      end else begin
         for (int p = 0; p < NUM_UPD; p++) begin
            if (!found && upd_valid[p] && upd_mispredict[p]) begin
               found = 1'b1;
               ghr_d = {upd_hist[p*GHR_BITS +: GHR_BITS-1], upd_taken[p]};
            end
         end
         if (!found && fetch_valid)
            ghr_d = {ghr_q[GHR_BITS-2:0], pred_taken};
      end
   end

   // Each port works on the state left by the older ports, so repeated hits accumulate.
   always_comb begin
      logic [ADDR_W-1:0]       pc;
      logic [GHR_BITS-1:0]     hist;
      logic                    tk, is_cond, g_ok, b_ok, h0, h1, way;
      logic [IDX_BITS-1:0]     gi, bi;
      logic [BTB_IDX_BITS-1:0] s;
      logic [ADDR_MAX-1:0]     tag;
      logic [1:0]              bt;
      gsh_d   = gsh_q;
      bim_d   = bim_q;
      cho_d   = cho_q;
      btb_d   = btb_q;
      lru_d   = lru_q;
      pc      = '0;
      hist    = '0;
      tk      = 1'b0;
      is_cond = 1'b0;
      g_ok    = 1'b0;
      b_ok    = 1'b0;
      h0      = 1'b0;
      h1      = 1'b0;
      way     = 1'b0;
      gi      = '0;
      bi      = '0;
      s       = '0;
      tag     = '0;
      bt      = BT_COND;
      for (int p = 0; p < NUM_UPD; p++) begin
         if (upd_valid[p] && !flush) begin
            pc      = upd_pc[p*ADDR_W +: ADDR_W];
            hist    = upd_hist[p*GHR_BITS +: GHR_BITS];
            tk      = upd_taken[p];
            is_cond = !(upd_is_call[p] || upd_is_return[p] || upd_is_jump[p]);
            if (is_cond) begin
               gi   = gsh_idx(hist, pc);
               bi   = pc_idx(pc);
               g_ok = (gsh_d[gi][1] == tk);
               b_ok = (bim_d[bi][1] == tk);
               if (g_ok != b_ok)
                  cho_d[bi] = g_ok ? sat_inc(cho_d[bi]) : sat_dec(cho_d[bi]);
               gsh_d[gi] = tk ? sat_inc(gsh_d[gi]) : sat_dec(gsh_d[gi]);
               bim_d[bi] = tk ? sat_inc(bim_d[bi]) : sat_dec(bim_d[bi]);
            end
            if (tk) begin
               s   = btb_set(pc);
               tag = btb_tag(pc);
               h0  = btb_d[s][0].valid && (btb_d[s][0].tag == tag);
               h1  = btb_d[s][1].valid && (btb_d[s][1].tag == tag);
               if (h0)                     way = 1'b0;
               else if (h1)                way = 1'b1;
               else if (!btb_d[s][0].valid) way = 1'b0;
               else if (!btb_d[s][1].valid) way = 1'b1;
               else                        way = lru_d[s];
               if (upd_is_call[p])        bt = BT_CALL;
               else if (upd_is_return[p]) bt = BT_RET;
               else if (upd_is_jump[p])   bt = BT_JUMP;
               else                       bt = BT_COND;
               btb_d[s][way] = '{valid: 1'b1, tag: tag,
                                 target: ADDR_MAX'(upd_target[p*ADDR_W +: ADDR_W]), btype: bt};
               lru_d[s] = ~way;
            end
         end
      end
   end

   // A port flagged both call and return behaves as a call.
   always_comb begin
      ras_push = '0;
      ras_pop  = '0;
      ras_addr = '0;
      for (int p = 0; p < NUM_UPD; p++) begin
         ras_push[p] = upd_valid[p] & upd_is_call[p] & ~flush;
         ras_pop[p]  = upd_valid[p] & upd_is_return[p] & ~upd_is_call[p] & ~flush;
         ras_addr[p*ADDR_W +: ADDR_W] = upd_pc[p*ADDR_W +: ADDR_W] + ADDR_W'(4);
      end
   end

   bp_ras #(
      .ADDR_W  (ADDR_W),
      .DEPTH   (RAS_DEPTH),
      .NUM_UPD (NUM_UPD)
   ) u_ras (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .push      (ras_push),
      .pop       (ras_pop),
      .push_addr (ras_addr),
      .count     (ras_cnt),
      .top       (ras_top)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < TBL; i++) begin
            gsh_q[i] <= 2'b01;
            bim_q[i] <= 2'b01;
            cho_q[i] <= 2'b01;
         end
         for (int i = 0; i < SETS; i++) begin
            btb_q[i][0] <= '0;
            btb_q[i][1] <= '0;
         end
         lru_q <= '0;
         ghr_q <= '0;
      end else begin
         gsh_q <= gsh_d;
         bim_q <= bim_d;
         cho_q <= cho_d;
         btb_q <= btb_d;
         lru_q <= lru_d;
         ghr_q <= ghr_d;
      end
   end

endmodule

// File: tb/tb_bp_tournament.sv
// Directed bench for bp_tournament: the driver queues hand-computed predictions per fetch,
// a negedge monitor pops and compares them whenever fetch_valid is presented.
module tb_bp_tournament;
   localparam int AW = 32;
   localparam int GB = 8;
   localparam int NU = 2;

   logic           clk, rst, flush, fetch_valid;
   logic [AW-1:0]  fetch_pc;
   logic           pred_taken, pred_btb_hit;
   logic [AW-1:0]  pred_target;
   logic [GB-1:0]  pred_hist;
   logic [NU-1:0]  upd_valid, upd_taken, upd_is_call, upd_is_return, upd_is_jump, upd_mispredict;
   logic [NU*AW-1:0] upd_pc, upd_target;
   logic [NU*GB-1:0] upd_hist;

   bp_tournament #(
      .ADDR_W(AW), .GHR_BITS(GB), .IDX_BITS(8), .BTB_IDX_BITS(6),
      .RAS_DEPTH(8), .NUM_UPD(NU), .FETCH_STRIDE(8)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
      .pred_taken(pred_taken), .pred_target(pred_target),
      .pred_hist(pred_hist), .pred_btb_hit(pred_btb_hit),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
      .upd_target(upd_target), .upd_hist(upd_hist),
      .upd_is_call(upd_is_call), .upd_is_return(upd_is_return),
      .upd_is_jump(upd_is_jump), .upd_mispredict(upd_mispredict)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic          tk;
      logic [AW-1:0] tgt;
      logic [GB-1:0] hist;
      logic          hit;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   nfetch = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL fetch#%0d pc=%h %s: got %h, expected %h", nfetch, fetch_pc, name, act, req);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst && fetch_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: fetch pc=%h presented with nothing queued", fetch_pc);
         end else begin
            e = exp_q.pop_front();
            nfetch++;
            check("pred_taken",   32'(pred_taken),   32'(e.tk));
            check("pred_target",  pred_target,       e.tgt);
            check("pred_hist",    32'(pred_hist),    32'(e.hist));
            check("pred_btb_hit", 32'(pred_btb_hit), 32'(e.hit));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      flush = 0; fetch_valid = 0; fetch_pc = '0;
      upd_valid = '0; upd_pc = '0; upd_taken = '0; upd_target = '0; upd_hist = '0;
      upd_is_call = '0; upd_is_return = '0; upd_is_jump = '0; upd_mispredict = '0;
   endtask

   task automatic do_reset();
      clear_in();
      rst = 1;
      tick();
      tick();
      rst = 0;
   endtask

   task automatic fetch(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                        input logic [7:0] h, input logic hit);
      exp_t e;
      e = '{tk: tk, tgt: tgt, hist: h, hit: hit};
      exp_q.push_back(e);
      fetch_valid = 1;
      fetch_pc    = pc;
      tick();
      fetch_valid = 0;
   endtask

   task automatic upd1(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                       input logic [7:0] h, input logic call, input logic ret);
      upd_valid[0] = 1; upd_pc[31:0] = pc; upd_taken[0] = tk; upd_target[31:0] = tgt;
      upd_hist[7:0] = h; upd_is_call[0] = call; upd_is_return[0] = ret;
      tick();
      clear_in();
   endtask

   // Both ports mispredict in one cycle alongside a fetch of 0x7000.
   task automatic dual_mispredict(input logic fl, input logic [31:0] p1pc, input logic [31:0] p1tgt,
                                  input logic [7:0] cur_hist);
      exp_t e;
      e = '{tk: 1'b0, tgt: 32'h7008, hist: cur_hist, hit: 1'b0};
      exp_q.push_back(e);
      fetch_valid = 1; fetch_pc = 32'h7000; flush = fl;
      upd_valid = 2'b11; upd_mispredict = 2'b11;
      upd_pc[31:0]  = 32'h1000; upd_taken[0] = 0; upd_target[31:0]  = '0;    upd_hist[7:0]  = 8'h0F;
      upd_pc[63:32] = p1pc;     upd_taken[1] = 1; upd_target[63:32] = p1tgt; upd_hist[15:8] = 8'h5A;
      tick();
      clear_in();
   endtask

   initial begin
      do_reset();

      // Reset state, then a conditional branch trained twice.
      fetch(32'h1000, 0, 32'h1008, 8'h00, 0);
      upd1(32'h1000, 1, 32'h2000, 8'h00, 0, 0);
      upd1(32'h1000, 1, 32'h2000, 8'h00, 0, 0);
      fetch(32'h1000, 1, 32'h2000, 8'h00, 1);
      fetch(32'h1000, 1, 32'h2000, 8'h01, 1);

      // Call/return round trip followed by another call.
      do_reset();
      upd1(32'h1100, 1, 32'h3000, 8'h00, 1, 0);
      upd1(32'h3010, 1, 32'h1104, 8'h00, 0, 1);
      upd1(32'h1200, 1, 32'h3000, 8'h00, 1, 0);
      fetch(32'h3010, 1, 32'h1204, 8'h00, 1);
      fetch(32'h1100, 1, 32'h3000, 8'h01, 1);

      // RAS overflow and underflow.
      do_reset();
      upd1(32'h3010, 1, 32'h5000, 8'h00, 0, 1);
      for (int k = 1; k <= 9; k++) upd1(32'(k * 32'h100), 1, 32'h4000, 8'h00, 1, 0);
      fetch(32'h3010, 1, 32'h0904, 8'h00, 1);
      for (int k = 0; k < 7; k++) upd1(32'h3010, 1, 32'h5000, 8'h00, 0, 1);
      fetch(32'h3010, 1, 32'h0204, 8'h01, 1);
      upd1(32'h3010, 1, 32'h5000, 8'h00, 0, 1);
      fetch(32'h3010, 1, 32'h5000, 8'h03, 1);
      upd1(32'h3010, 1, 32'h5000, 8'h00, 0, 1);
      fetch(32'h3010, 1, 32'h5000, 8'h07, 1);

      // Same-cycle mispredicts, then the same with flush.
      do_reset();
      dual_mispredict(0, 32'h2000, 32'h6000, 8'h00);
      fetch(32'h7000, 0, 32'h7008, 8'h1E, 0);
      fetch(32'h2000, 0, 32'h6000, 8'h3C, 1);
      dual_mispredict(1, 32'h2400, 32'h6400, 8'h78);
      fetch(32'h2400, 0, 32'h2408, 8'h00, 0);
      fetch(32'h2000, 0, 32'h6000, 8'h00, 1);

      // LRU replacement in set 0.
      do_reset();
      upd1(32'h0000, 1, 32'h0100, 8'h00, 0, 0);
      upd1(32'h1000, 1, 32'h0200, 8'h00, 0, 0);
      upd1(32'h2000, 1, 32'h0300, 8'h00, 0, 0);
      fetch(32'h0000, 0, 32'h0008, 8'h00, 0);
      fetch(32'h1000, 1, 32'h0200, 8'h00, 1);
      fetch(32'h2000, 1, 32'h0300, 8'h01, 1);

      // Two ports on the same counter move it twice; one not-taken leaves it weakly taken.
      do_reset();
      upd_valid = 2'b11; upd_taken = 2'b11;
      upd_pc[31:0] = 32'h40; upd_pc[63:32] = 32'h40;
      upd_target[31:0] = 32'h9000; upd_target[63:32] = 32'h9000;
      tick();
      clear_in();
      upd1(32'h40, 0, 32'h0, 8'h00, 0, 0);
      fetch(32'h40, 1, 32'h9000, 8'h00, 1);

      tick();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bp_tournament.md
Name: bp_tournament

Overview:
Second-generation front-end branch predictor. It combines a gshare table and a bimodal table, with a per-PC chooser selecting between them, and adds a set-associative BTB with typed entries, a speculative GHR with mispredict recovery, and a circular RAS. The fetch stage queries it combinationally. A parametrised number of in-order resolution ports from the backend update it.

Parameters:
ADDR_W, 32, instruction address width
GHR_BITS, 8, global history length (must be ≥ 2)
IDX_BITS, 8, log2 entries of the gshare, bimodal and chooser tables
BTB_IDX_BITS, 6, log2 BTB sets; BTB is 2-way
RAS_DEPTH, 8, RAS entries (power of two)
NUM_UPD, 2, number of resolution ports
FETCH_STRIDE, 8, fall-through increment (IF_BATCH_SIZE*INST_ADD_STEP)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
flush  in  1  pipeline flush
fetch_valid  in  1  fetch query valid
fetch_pc  in  ADDR_W  fetch address
pred_taken  out  1  predicted taken
pred_target  out  ADDR_W  predicted next PC
pred_hist  out  GHR_BITS  speculative GHR used for this prediction
pred_btb_hit  out  1  BTB hit for fetch_pc
upd_valid  in  NUM_UPD  per-port resolution valid; port 0 is oldest
upd_pc  in  NUM_UPD*ADDR_W  branch PC
upd_taken  in  NUM_UPD  actual outcome
upd_target  in  NUM_UPD*ADDR_W  actual target
upd_hist  in  NUM_UPD*GHR_BITS  pred_hist captured at fetch
upd_is_call  in  NUM_UPD  call
upd_is_return  in  NUM_UPD  return
upd_is_jump  in  NUM_UPD  other unconditional jump
upd_mispredict  in  NUM_UPD  prediction was wrong

Behaviour:
- Reset (async, rst=1):
  - GHR = 0.
  - RAS pointer and count = 0.
  - All gshare and bimodal counters = 01 (weakly not taken); chooser counters = 01 (weakly bimodal).
  - All BTB valid and LRU bits = 0.
  - Outputs then read: pred_taken=0, pred_btb_hit=0, pred_hist=0, pred_target=fetch_pc+FETCH_STRIDE.
- Prediction (combinational, no bypass of same-cycle updates):
  - Indices: gidx = GHR[IDX-1:0] ^ pc[IDX+1:2], zero-extending GHR when GHR_BITS < IDX_BITS. bidx = cidx = pc[IDX+1:2].
  - BTB set = pc[BTB_IDX+1:2]; tag = pc[ADDR_W-1:BTB_IDX+2]. Hit if either valid way's tag matches; way 0 wins if both match.
  - Entry type: 00 cond, 01 call, 10 ret, 11 jump.
  - Direction: chooser[1] ? gshare[1] : bimodal[1].
  - pred_taken = fetch_valid & hit & (type≠cond | direction).
  - pred_target priority: hit & ret & RAS nonempty → RAS top; hit → BTB target; else fetch_pc+FETCH_STRIDE.
- Speculative GHR, evaluated each cycle in priority order:
  1. flush → 0.
  2. Else, any upd_valid&upd_mispredict → lowest such port p wins: GHR = {upd_hist[p][GHR-2:0], upd_taken[p]}.
  3. Else fetch_valid → GHR = {GHR[GHR-2:0], pred_taken}.
- Updates are applied sequentially in port order within one cycle; later ports see earlier ports' effects.
  - Two ports hitting the same counter move it twice.
  - Ports younger than a mispredicting port are still applied to the tables. Only GHR selection is affected by the mispredict priority.
- Counters (conditional branches only):
  - gshare is indexed with upd_hist; bimodal with pc. Both saturate at 00 and 11.
  - Chooser updates only when the two components disagree: +1 toward gshare if gshare was correct, −1 if bimodal was correct; saturating.
- BTB (on taken only):
  - On a hit, overwrite that way.
  - On a miss, fill an invalid way, way 0 first; if both are valid, replace the LRU way.
  - Write tag, target and type. Type priority: call > return > jump > cond.
  - Set the set's LRU bit to the other way.
- RAS (circular):
  - Call: write pc+4 at the pointer, pointer+1 with wrap, count = min(count+1, RAS_DEPTH). When full, the push overwrites the oldest entry.
  - Return with count>0: pointer−1 and count−1. Return with count=0: no change.
  - If one port has both call and return set, treat it as a call.
- flush: clears GHR and RAS only; tables keep their contents. All updates in that cycle are discarded. Reset overrides flush.

Decomposition:
- Shared package bp_pkg:
  - BTB type encoding constants.
  - Functions: make_gshare_idx, sat_inc, sat_dec.
  - BTB entry struct: valid, tag, target, type.
- One sub-module, bp_ras: circular stack with push/pop/flush, count and top output.

Test Plan:
- Reset, then fetch_pc=0x1000 → pred_taken=0, pred_btb_hit=0, pred_target=0x1008, pred_hist=0x00.
- Port 0 taken cond, pc=0x1000, target=0x2000, hist=0, mispredict=0, applied twice; then fetch 0x1000 with GHR=0 → pred_btb_hit=1, pred_taken=1, pred_target=0x2000; gshare[0] and bimodal[0] = 11.
- Round-trip (call at 0x1100 to 0x3000, return at 0x3010 to 0x1104), then another call update at 0x1200 → fetch 0x3010 gives pred_taken=1, pred_target=0x1204.
- Nine calls at pc 0x100..0x900 (step 0x100) → RAS top=0x904, count=8. Eight returns → count 0. A ninth return leaves RAS unchanged, and a return fetch then uses the BTB target.
- Same cycle: port 0 mispredict hist=0x0F taken=0, port 1 mispredict hist=0x5A taken=1, fetch_valid=1 → next GHR=0x1E. Repeat with flush=1 → GHR=0x00 and no table changes.
- Taken cond branches A=0x0000, B=0x1000, C=0x2000 (same set 0, distinct tags) installed in order → after C, fetch A misses, B hits, C hits.
